flag_pc_unit: RTL and testbench
===============================

// Module: flag_pc_unit
// PURPOSE
//  Downstream consumer of the ALU's FLAG output. Holds the architectural N/V/Z flag
//  register and feeds it back as the ALU's FLAG_in. Owns the 16-bit PC and produces
//  the next PC: sequential, PC-relative branch (B), register branch (BR) or halt.
//  Sits between the ALU/decode and instruction fetch of the single-cycle datapath.
// PARAMETERS
//  RESET_PC  16'h0000  PC value loaded on reset
// PORTS
//  clk         in   1   clock, rising-edge
//  rst_n       in   1   reset, asynchronous, active-low
//  stall       in   1   hold PC, flags and state this cycle
//  flag_we     in   1   capture alu_flag at the next edge
//  alu_flag    in   3   ALU FLAG: [0]=N, [1]=V, [2]=Z
//  branch      in   1   current instruction is B or BR
//  branch_reg  in   1   1 = BR (target reg_target); 0 = B (PC-relative)
//  cond        in   3   branch condition code
//  imm9        in   9   signed word offset for B
//  reg_target  in  16   target address for BR
//  halt        in   1   current instruction is HLT
//  flag        out  3   registered flags, same bit order as alu_flag (to ALU FLAG_in)
//  pc          out 16   current instruction address (to fetch)
//  pc_plus2    out 16   pc + 2, mod 2^16, combinational (link/writeback use)
//  taken       out  1   combinational: branch taken this cycle
//  halted      out  1   1 while in HALTED
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): pc=RESET_PC, flag=3'b000, state=RUN, halted=0.
//    Takes effect immediately, including mid-branch, mid-stall and in HALTED.
//  - FSM, two states: RUN, HALTED.
//    RUN -> HALTED at an edge where halt=1 and stall=0. HALTED exits only on reset.
//  - Conditions are evaluated on the REGISTERED flag (Z=flag[2], V=flag[1], N=flag[0]):
//    000 NE !Z | 001 EQ Z | 010 GT !Z&!N | 011 LT N | 100 GE Z|!N | 101 LE N|Z
//    110 OV V | 111 always
//  - taken = RUN & !stall & !halt & branch & cond_met.
//  - Next-PC priority in RUN (all arithmetic 16-bit, wraps mod 2^16, no overflow flag):
//      stall=1 -> pc held
//      halt=1  -> pc held (points at HLT)
//      taken=1 & branch_reg=1 -> reg_target
//      taken=1 & branch_reg=0 -> pc_plus2 + (sign_ext(imm9) << 1)
//      otherwise -> pc_plus2
//  - In HALTED: pc held, taken=0, halted=1. flag_we, branch and halt are ignored.
//  - Flag register:
//      flag <= alu_flag at the edge where flag_we=1 & stall=0 & state=RUN.
//      Otherwise flag is held.
//  - Same-cycle flag_we and branch: the branch sees the OLD flags. The new flags are
//    visible to the next instruction.
//  - halt and branch asserted together: halt wins, taken=0.
//  - Single-cycle latency: pc, flag and state update at the same rising edge. taken and
//    pc_plus2 are pure combinational from the current registers and inputs.
//  - Flag updates are whole-word. Per-flag preservation is handled upstream by the ALU's
//    FLAG_in muxing.
// TESTING
//  1 pc=16'h0040, pulse rst_n=0 between edges -> pc=16'h0000, flag=000, halted=0
//    before the next edge.
//  2 flag_we=1, alu_flag=3'b100, branch=1, cond=001 (EQ) in the same cycle -> taken=0,
//    pc+=2, flag=100. Repeat the branch next cycle -> taken=1.
//  3 pc=16'h0010, B, cond=111, imm9=9'h1FF -> pc=16'h0010. With imm9=9'h0FF -> 16'h0210.
//  4 pc=16'hFFFE, no branch -> pc_plus2=16'h0000 and pc wraps to 16'h0000.
//    B at 16'hFFFE with imm9=9'h001 -> pc=16'h0002.
//  5 flag=001 (N), BR, cond=011 (LT), reg_target=16'h1234 -> pc=16'h1234.
//    flag=000, same branch -> taken=0, pc+=2. stall=1 with the branch -> pc and flag held.
//  6 pc=16'h0020, halt=1 -> halted=1, pc stays 16'h0020 for 10+ cycles.
//    flag_we=1 and branch pulses ignored. rst_n=0 -> RUN, pc=16'h0000.

Source files
------------

// File: rtl/flag_pc_unit.sv
// Flag register and program counter for the single-cycle datapath.
// The unit holds the N/V/Z flags that are fed back to the ALU and produces the next PC.
// The next PC is one of: sequential, PC-relative branch, register branch, or halt.
module flag_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flag_we,
  input  logic [2:0]  alu_flag,
  input  logic        branch,
  input  logic        branch_reg,
  input  logic [2:0]  cond,
  input  logic [8:0]  imm9,
  input  logic [15:0] reg_target,
  input  logic        halt,
  output logic [2:0]  flag,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        taken,
  output logic        halted
);

  localparam int unsigned PC_W   = 16;
  localparam int unsigned FLAG_W = 3;
  localparam int unsigned IMM_W  = 9;
  localparam int unsigned EXT_W  = PC_W - IMM_W - 1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [FLAG_W-1:0] flag_q, flag_d;
  logic              cond_met;
  logic              run;
  logic [PC_W-1:0]   br_off;

  assign run      = (state_q == ST_RUN);
  assign pc_plus2 = pc_q + PC_W'(2);
  assign br_off   = {{EXT_W{imm9[IMM_W-1]}}, imm9, 1'b0};
  assign taken    = run & ~stall & ~halt & branch & cond_met;

  // Branch condition decode against the registered flags (Z=[2], V=[1], N=[0])
  always_comb begin
    cond_met = 1'b0;
    unique case (cond)
      3'b000:  cond_met = ~flag_q[2];
      3'b001:  cond_met = flag_q[2];
      3'b010:  cond_met = ~flag_q[2] & ~flag_q[0];
      3'b011:  cond_met = flag_q[0];
      3'b100:  cond_met = flag_q[2] | ~flag_q[0];
      3'b101:  cond_met = flag_q[0] | flag_q[2];
      3'b110:  cond_met = flag_q[1];
      default: cond_met = 1'b1;
    endcase
  end

  // Next-state, next-PC and flag-capture selection; everything holds unless running unstalled
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flag_d  = flag_q;
    if (run && !stall) begin
      if (flag_we) begin
        flag_d = alu_flag;
      end
      if (halt) begin
        state_d = ST_HALTED;
      end else if (taken) begin
        pc_d = branch_reg ? reg_target : (pc_plus2 + br_off);
      end else begin
        pc_d = pc_plus2;
      end
    end
  end

  // State, PC and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flag_q  <= flag_d;
    end
  end

  assign pc     = pc_q;
  assign flag   = flag_q;
  assign halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_flag_pc_unit.sv
// Scoreboard bench for flag_pc_unit: directed scenarios followed by random traffic.
module tb_flag_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flag_we;
  logic [2:0]  alu_flag;
  logic        branch;
  logic        branch_reg;
  logic [2:0]  cond;
  logic [8:0]  imm9;
  logic [15:0] reg_target;
  logic        halt;
  logic [2:0]  flag;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        taken;
  logic        halted;

  flag_pc_unit #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flag_we    (flag_we),
    .alu_flag   (alu_flag),
    .branch     (branch),
    .branch_reg (branch_reg),
    .cond       (cond),
    .imm9       (imm9),
    .reg_target (reg_target),
    .halt       (halt),
    .flag       (flag),
    .pc         (pc),
    .pc_plus2   (pc_plus2),
    .taken      (taken),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        rst;
    bit        stall;
    bit        flag_we;
    bit [2:0]  alu_flag;
    bit        branch;
    bit        branch_reg;
    bit [2:0]  cond;
    bit [8:0]  imm9;
    bit [15:0] reg_target;
    bit        halt;
  } stim_t;

  typedef struct {
    int        idx;
    bit [15:0] pc;
    bit [2:0]  flag;
    bit        halted;
    bit        taken;
    bit [15:0] pp2;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;

  // Reference model: architectural state as plain integers
  int   m_pc = 0;
  int   m_n = 0, m_v = 0, m_z = 0;
  bit   m_halted = 1'b0;

  function automatic bit cond_ok(int c, int n, int v, int z);
    case (c)
      0: return z == 0;
      1: return z == 1;
      2: return (z == 0) && (n == 0);
      3: return n == 1;
      4: return (z == 1) || (n == 0);
      5: return (n == 1) || (z == 1);
      6: return v == 1;
      default: return 1'b1;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t jump_to(bit [15:0] tgt);
    stim_t s;
    s = idle();
    s.branch = 1; s.branch_reg = 1; s.cond = 3'd7; s.reg_target = tgt;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit   tk;
    int   off;
    @(posedge clk);
    #1;
    stall = s.stall; flag_we = s.flag_we; alu_flag = s.alu_flag;
    branch = s.branch; branch_reg = s.branch_reg; cond = s.cond;
    imm9 = s.imm9; reg_target = s.reg_target; halt = s.halt;
    if (s.rst) begin
      rst_n = 1'b0;
      m_pc = 0; m_n = 0; m_v = 0; m_z = 0; m_halted = 1'b0;
    end
    tk = !m_halted && !s.stall && !s.halt && s.branch && cond_ok(int'(s.cond), m_n, m_v, m_z);
    e.idx = step_no; e.pc = 16'(m_pc); e.flag = {3{1'b0}};
    e.flag[2] = (m_z != 0); e.flag[1] = (m_v != 0); e.flag[0] = (m_n != 0);
    e.halted = m_halted; e.taken = tk; e.pp2 = 16'((m_pc + 2) % 65536);
    exp_q.push_back(e);
    step_no++;
    if (!m_halted && !s.stall) begin
      if (s.flag_we) begin
        m_n = int'(s.alu_flag[0]); m_v = int'(s.alu_flag[1]); m_z = int'(s.alu_flag[2]);
      end
      if (s.halt) m_halted = 1'b1;
      else if (tk && s.branch_reg) m_pc = int'(s.reg_target);
      else if (tk) begin
        off = (int'(s.imm9) >= 256) ? int'(s.imm9) - 512 : int'(s.imm9);
        m_pc = ((m_pc + 2 + off * 2) % 65536 + 65536) % 65536;
      end else m_pc = (m_pc + 2) % 65536;
    end
    if (s.rst) begin
      @(negedge clk);
      #1 rst_n = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, idx, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",       e.idx, int'(pc),       int'(e.pc));
        chk("flag",     e.idx, int'(flag),     int'(e.flag));
        chk("halted",   e.idx, int'(halted),   int'(e.halted));
        chk("taken",    e.idx, int'(taken),    int'(e.taken));
        chk("pc_plus2", e.idx, int'(pc_plus2), int'(e.pp2));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    int    wait_cnt;
    rst_n = 1'b0; stall = 0; flag_we = 0; alu_flag = '0; branch = 0; branch_reg = 0;
    cond = '0; imm9 = '0; reg_target = '0; halt = 0;
    s = idle(); s.rst = 1; step(s);

    // Asynchronous reset between edges from a non-zero PC
    step(jump_to(16'h0040));
    s = idle(); s.rst = 1; step(s);

    // Same-cycle flag write and branch: the branch sees the old flags
    s = idle(); s.flag_we = 1; s.alu_flag = 3'b100; s.branch = 1; s.cond = 3'b001; step(s);
    s = idle(); s.branch = 1; s.cond = 3'b001; s.imm9 = 9'h004; step(s);
    step(idle());

    // PC-relative branch with negative and positive offsets
    step(jump_to(16'h0010));
    s = idle(); s.branch = 1; s.cond = 3'd7; s.imm9 = 9'h1FF; step(s);
    step(jump_to(16'h0010));
    s = idle(); s.branch = 1; s.cond = 3'd7; s.imm9 = 9'h0FF; step(s);
    step(idle());

    // Wrap at the top of the address space
    step(jump_to(16'hFFFE));
    step(idle());
    step(jump_to(16'hFFFE));
    s = idle(); s.branch = 1; s.cond = 3'd7; s.imm9 = 9'h001; step(s);
    step(idle());

    // Register branch on LT, not-taken after clearing N, stall holding everything
    s = idle(); s.flag_we = 1; s.alu_flag = 3'b001; step(s);
    s = jump_to(16'h1234); s.cond = 3'b011; step(s);
    s = idle(); s.flag_we = 1; s.alu_flag = 3'b000; step(s);
    s = jump_to(16'h1234); s.cond = 3'b011; step(s);
    s = jump_to(16'h1234); s.cond = 3'd7; s.stall = 1; s.flag_we = 1; s.alu_flag = 3'b111; step(s);
    step(idle());

    // Halt: PC frozen, flag writes and branches ignored, reset recovers
    step(jump_to(16'h0020));
    s = idle(); s.halt = 1; s.branch = 1; s.cond = 3'd7; step(s);
    for (int i = 0; i < 12; i++) begin
      s = jump_to(16'($urandom)); s.flag_we = 1; s.alu_flag = 3'($urandom_range(0, 7));
      s.halt = (i % 3 == 0);
      step(s);
    end
    s = idle(); s.rst = 1; step(s);
    step(idle());

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      s.rst        = ($urandom_range(0, 59) == 0) || (m_halted && $urandom_range(0, 5) == 0);
      s.stall      = ($urandom_range(0, 5) == 0);
      s.flag_we    = $urandom_range(0, 1) == 1;
      s.alu_flag   = 3'($urandom_range(0, 7));
      s.branch     = $urandom_range(0, 2) != 0;
      s.branch_reg = $urandom_range(0, 1) == 1;
      s.cond       = 3'($urandom_range(0, 7));
      s.imm9       = 9'($urandom_range(0, 511));
      s.reg_target = 16'($urandom_range(0, 65535));
      s.halt       = ($urandom_range(0, 39) == 0);
      step(s);
    end
    step(idle());

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    chk("drain", step_no, exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
